imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
// - Registered, parametrised immediate generator for the decode stage of the RISC-V pipeline.
// - Takes a full 32-bit instruction and produces an XLEN sign-extended immediate and an illegal flag.
// - Format comes either from opcode auto-detect or from an explicit fmt code.
// - Sits between IF/ID and ID/EX. Uses a valid/ready handshake with a 2-entry skid buffer so ID can stall without losing work.
// PARAMETERS
// - XLEN      32  immediate width; 32 or 64; all formats sign-extend from inst[31] to XLEN.
// - AUTO_FMT  1   1: format decoded from inst[6:0]; 0: format taken from in_fmt.
// - TAG_W     32  width of the sideband tag (PC/rd), passed through unchanged.
// - CNT_W     16  width of the saturating illegal-instruction counter.
// PORTS
// - clk          in   1      rising-edge clock.
// - rst_n        in   1      asynchronous active-low reset.
// - flush        in   1      synchronous pipeline flush (branch mispredict).
// - in_valid     in   1      input instruction valid.
// - in_ready     out  1      block can accept an instruction this cycle.
// - in_inst      in   32     instruction word.
// - in_fmt       in   3      000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal; used only when AUTO_FMT=0.
// - in_tag       in   TAG_W  sideband tag.
// - out_valid    out  1      output entry valid.
// - out_ready    in   1      downstream accepts the entry.
// - out_imm      out  XLEN   generated immediate.
// - out_fmt      out  3      resolved format code.
// - out_illegal  out  1      no immediate format exists for this entry.
// - out_tag      out  TAG_W  tag of the entry.
// - illegal_cnt  out  CNT_W  count of illegal entries accepted, saturating.
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, illegal_cnt=0.
//   - Both buffer entries invalid, so in_ready=1.
// - Formats, with s = inst[31] replicated to XLEN:
//   - I: {s, inst[31:20]}
//   - S: {s, inst[31:25], inst[11:7]}
//   - B: {s, inst[31], inst[7], inst[30:25], inst[11:8], 0}
//   - U: {s, inst[31:12], 12'b0}
//   - J: {s, inst[31], inst[19:12], inst[20], inst[30:21], 0}
// - AUTO_FMT=1 opcode map:
//   - 0010011 / 0000011 / 1100111 / 1110011 -> I
//   - 0100011 -> S
//   - 1100011 -> B
//   - 0110111 / 0010111 -> U
//   - 1101111 -> J
//   - anything else -> illegal, out_fmt=111.
// - An illegal entry has out_imm=0 and out_illegal=1.
// - Immediate computation is combinational on the input and registered at accept.
// - Latency: accepted at edge N, presented on out_* from edge N (one cycle), assuming no backpressure.
// - Accept when in_valid & in_ready. Output transfer when out_valid & out_ready.
// - out_* hold stable while out_valid=1 and out_ready=0.
// - Skid buffer: main register drives the outputs; skid register catches the accept made while main is stalled.
//   - in_ready = ~skid_valid, driven from a flop with no combinational path from out_ready.
//   - When main is popped, skid moves into main on the same edge.
//   - Order is preserved; no entry is ever dropped or duplicated.
// - Simultaneous accept and pop with skid empty: new entry goes to main; no bubble.
// - Full condition (main and skid valid): in_ready=0 next cycle; in_valid is ignored.
// - Flush:
//   - Clears both valid bits on the edge and discards any same-cycle accept.
//   - Next cycle: out_valid=0, in_ready=1.
//   - Flush does not clear illegal_cnt; a discarded accept is not counted.
// - illegal_cnt increments by 1 per accepted illegal entry and sticks at 2^CNT_W-1.
// - Reset mid-operation: all state is cleared immediately, independent of clk.
// TESTING
// - Decode, XLEN=32, out_ready=1:
//   - 0xFFF00093 (addi -1) -> imm 0xFFFFFFFF, fmt 000, valid 1 cycle after accept.
//   - 0xFE112E23 (sw -4) -> imm 0xFFFFFFFC, fmt 001.
// - Decode, XLEN=32: 0xFFDFF06F (jal -4) -> imm 0xFFFFFFFC, fmt 100.
//   - 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, fmt 010.
// - XLEN=64: 0x800000B7 (lui 0x80000) -> imm 0xFFFFFFFF80000000.
//   - 0x0000007F -> out_illegal=1, imm 0, fmt 111, illegal_cnt 0->1.
// - Backpressure: stream 5 instructions with out_ready=0 for cycles 2-4.
//   - in_ready=0 after 2 accepts.
//   - All 5 emerge in order with correct tags; none lost or duplicated.
// - Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged.
// - Assert rst_n=0 between clock edges with entries pending:
//   - out_valid=0 and illegal_cnt=0 immediately.
//   - Counter saturation at CNT_W=2 holds at 3.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RISC-V immediate generator with 2-entry skid buffer
//
// Purpose: decodes the immediate of a 32-bit instruction (format from opcode or
// from in_fmt), sign-extends it to XLEN and registers it between IF/ID and ID/EX.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous flush, drops both buffered entries and any same-cycle accept
//   in_valid/in_ready   input handshake; in_ready is a flop (no path from out_ready)
//   in_inst/in_fmt      instruction word, explicit format (used when AUTO_FMT=0)
//   in_tag              sideband tag, passed through unchanged
//   out_valid/out_ready output handshake
//   out_imm/out_fmt     immediate and resolved format (111 when illegal in auto mode)
//   out_illegal         no immediate format for this entry (out_imm is 0)
//   out_tag             tag of the presented entry
//   illegal_cnt         saturating count of accepted illegal entries
module imm_gen_pipe #(
   parameter int XLEN     = 32,
   parameter int AUTO_FMT = 1,
   parameter int TAG_W    = 32,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_fmt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] illegal_cnt
);

   // ---------------- combinational decode of the incoming instruction
   logic [2:0]      fmt_dec;
   logic            ill_dec;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_dec;
   logic            s;

   assign s = in_inst[31];

   always_comb begin
      fmt_dec = 3'b111;
      if (AUTO_FMT != 0) begin
         case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt_dec = 3'b000;
            7'b0100011:                                     fmt_dec = 3'b001;
            7'b1100011:                                     fmt_dec = 3'b010;
            7'b0110111, 7'b0010111:                         fmt_dec = 3'b011;
            7'b1101111:                                     fmt_dec = 3'b100;
            default:                                        fmt_dec = 3'b111;
         endcase
      end else begin
         fmt_dec = in_fmt;
      end
   end

   assign ill_dec = (fmt_dec > 3'b100);

   always_comb begin
      imm32 = 32'd0;
      case (fmt_dec)
         3'b000:  imm32 = {{20{s}}, in_inst[31:20]};
         3'b001:  imm32 = {{20{s}}, in_inst[31:25], in_inst[11:7]};
         3'b010:  imm32 = {{19{s}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
         3'b011:  imm32 = {in_inst[31:12], 12'd0};
         3'b100:  imm32 = {{11{s}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
         default: imm32 = 32'd0;
      endcase
   end

   // Every format's bit 31 already equals inst[31], so widening to XLEN just
   // replicates it; this form also covers XLEN=32 without a zero-width replicate.
   always_comb begin
      imm_dec = {XLEN{s}};
      imm_dec[31:0] = imm32;
      if (ill_dec) begin
         imm_dec = '0;
      end
   end

   // ---------------- main / skid registers
   logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic [XLEN-1:0]  main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
   logic [2:0]       main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;
   logic             main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
   logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, pop;

   assign in_ready = ~skid_v_q;
   assign accept   = in_valid & in_ready & ~flush;
   assign pop      = main_v_q & out_ready;

   always_comb begin
      main_v_d   = main_v_q;
      main_imm_d = main_imm_q;
      main_fmt_d = main_fmt_q;
      main_ill_d = main_ill_q;
      main_tag_d = main_tag_q;
      skid_v_d   = skid_v_q;
      skid_imm_d = skid_imm_q;
      skid_fmt_d = skid_fmt_q;
      skid_ill_d = skid_ill_q;
      skid_tag_d = skid_tag_q;
      cnt_d      = cnt_q;

      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (!main_v_q || pop) begin
         if (skid_v_q) begin
            // in_ready is low while skid holds data, so no accept can race this move
            main_v_d   = 1'b1;
            main_imm_d = skid_imm_q;
            main_fmt_d = skid_fmt_q;
            main_ill_d = skid_ill_q;
            main_tag_d = skid_tag_q;
            skid_v_d   = 1'b0;
         end else begin
            main_v_d = accept;
            if (accept) begin
               main_imm_d = imm_dec;
               main_fmt_d = fmt_dec;
               main_ill_d = ill_dec;
               main_tag_d = in_tag;
            end
         end
      end else if (accept) begin
         skid_v_d   = 1'b1;
         skid_imm_d = imm_dec;
         skid_fmt_d = fmt_dec;
         skid_ill_d = ill_dec;
         skid_tag_d = in_tag;
      end

      if (accept && ill_dec && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v_q   <= 1'b0;
         main_imm_q <= '0;
         main_fmt_q <= 3'b000;
         main_ill_q <= 1'b0;
         main_tag_q <= '0;
         skid_v_q   <= 1'b0;
         skid_imm_q <= '0;
         skid_fmt_q <= 3'b000;
         skid_ill_q <= 1'b0;
         skid_tag_q <= '0;
         cnt_q      <= '0;
      end else begin
         main_v_q   <= main_v_d;
         main_imm_q <= main_imm_d;
         main_fmt_q <= main_fmt_d;
         main_ill_q <= main_ill_d;
         main_tag_q <= main_tag_d;
         skid_v_q   <= skid_v_d;
         skid_imm_q <= skid_imm_d;
         skid_fmt_q <= skid_fmt_d;
         skid_ill_q <= skid_ill_d;
         skid_tag_q <= skid_tag_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid   = main_v_q;
   assign out_imm     = main_imm_q;
   assign out_fmt     = main_fmt_q;
   assign out_illegal = main_ill_q;
   assign out_tag     = main_tag_q;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64/CNT_W=2 instances)
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_inst, in_tag;
   logic [2:0]  in_fmt;

   logic        rdy32, v32, ill32, rdy64, v64, ill64;
   logic [31:0] imm32, tag32, tag64;
   logic [63:0] imm64;
   logic [2:0]  fmt32, fmt64;
   logic [15:0] cnt32;
   logic [1:0]  cnt64;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] tag;
   } ent_t;
   ent_t q[$];
   int   mcnt = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .AUTO_FMT(1), .TAG_W(32), .CNT_W(16)) u32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .in_inst(in_inst), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(v32),
      .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32),
      .out_tag(tag32), .illegal_cnt(cnt32));

   imm_gen_pipe #(.XLEN(64), .AUTO_FMT(1), .TAG_W(32), .CNT_W(2)) u64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .in_inst(in_inst), .in_fmt(in_fmt), .in_tag(in_tag), .out_valid(v64),
      .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64),
      .out_tag(tag64), .illegal_cnt(cnt64));

   // ---------------- reference model
   function automatic logic [2:0] ref_fmt(input logic [31:0] i);
      case (i[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return 3'd0;
         7'b0100011: return 3'd1;
         7'b1100011: return 3'd2;
         7'b0110111, 7'b0010111: return 3'd3;
         7'b1101111: return 3'd4;
         default: return 3'd7;
      endcase
   endfunction

   // Immediate as a signed number: unsigned field value minus 2^width when inst[31] is set.
   function automatic logic [63:0] ref_imm(input logic [31:0] i);
      longint sgn, v;
      sgn = i[31] ? -1 : 0;
      case (ref_fmt(i))
         3'd0: v = sgn * 4096 + longint'(i[31:20]);
         3'd1: v = sgn * 4096 + longint'({i[31:25], i[11:7]});
         3'd2: v = sgn * 8192 + longint'({i[31], i[7], i[30:25], i[11:8], 1'b0});
         3'd3: v = sgn * (longint'(1) << 32) + longint'({i[31:12], 12'd0});
         3'd4: v = sgn * (longint'(1) << 21) + longint'({i[31], i[19:12], i[20], i[30:21], 1'b0});
         default: v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [10];
      logic [31:0] r;
      ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000};
      r = $urandom();
      ops[9] = r[6:0];
      return {r[31:7], ops[$urandom_range(0, 9)]};
   endfunction

   // Advance one clock, updating the model from the inputs held across the edge.
   task automatic tick();
      bit   acc, pop;
      ent_t e;
      acc = in_valid && (q.size() < 2) && !flush;
      pop = (q.size() > 0) && out_ready;
      e.inst = in_inst;
      e.tag  = in_tag;
      @(posedge clk);
      if (flush) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) begin
            q.push_back(e);
            if (ref_fmt(e.inst) == 3'd7) mcnt++;
         end
      end
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
   endtask

   // ---------------- tests
   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = 32'd0; in_tag = 32'd0; in_fmt = 3'd0;
      @(negedge clk);
      n_cmp++;
      if ({v32, v64, rdy32, rdy64} !== 4'b0011) begin
         n_fail++; $display("FAIL reset_handshake: got v=%b%b rdy=%b%b want v=00 rdy=11", v32, v64, rdy32, rdy64);
      end
      n_cmp++;
      if ({imm32, fmt32, ill32, tag32, cnt32} !== 84'd0 || {imm64, fmt64, ill64, tag64, cnt64} !== 102'd0) begin
         n_fail++; $display("FAIL reset_data: got imm32=%h imm64=%h fmt=%0d/%0d ill=%b/%b tag=%h/%h cnt=%0d/%0d want all 0",
                            imm32, imm64, fmt32, fmt64, ill32, ill64, tag32, tag64, cnt32, cnt64);
      end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      mcnt = 0;
   endtask

   task automatic test_decode();
      logic [31:0] d_inst [6];
      logic [63:0] d_imm [6];
      logic [2:0]  d_fmt [6];
      logic [63:0] e;
      d_inst = '{32'hFFF00093, 32'hFE112E23, 32'hFFDFF06F, 32'hFE000EE3, 32'h800000B7, 32'h0000007F};
      d_imm  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'h0};
      d_fmt  = '{3'd0, 3'd1, 3'd4, 3'd2, 3'd3, 3'd7};
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1;
         in_inst = d_inst[k];
         in_tag = 32'hA000 + k;
         tick();
         e = d_imm[k];
         n_cmp++;
         if ({v32, imm32, fmt32, ill32, tag32} !== {1'b1, e[31:0], d_fmt[k], d_fmt[k] == 3'd7, 32'hA000 + k}) begin
            n_fail++; $display("FAIL decode32 %h: got v=%b imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d",
                               d_inst[k], v32, imm32, fmt32, ill32, tag32, e[31:0], d_fmt[k]);
         end
         n_cmp++;
         if ({v64, imm64, fmt64, ill64} !== {1'b1, e, d_fmt[k], d_fmt[k] == 3'd7}) begin
            n_fail++; $display("FAIL decode64 %h: got v=%b imm=%h fmt=%0d ill=%b want imm=%h fmt=%0d",
                               d_inst[k], v64, imm64, fmt64, ill64, e, d_fmt[k]);
         end
         n_cmp++;
         if (cnt32 !== ((k == 5) ? 16'd1 : 16'd0) || cnt64 !== ((k == 5) ? 2'd1 : 2'd0)) begin
            n_fail++; $display("FAIL decode_cnt step %0d: got %0d/%0d want %0d", k, cnt32, cnt64, (k == 5) ? 1 : 0);
         end
      end
      in_valid = 1'b0;
      drain();
   endtask

   task automatic test_backpressure();
      logic [31:0] bp_inst [5];
      logic [63:0] e;
      int sent = 0;
      int got = 0;
      bp_inst = '{32'hFFF00093, 32'h0000007F, 32'hFE112E23, 32'h800000B7, 32'hFFDFF06F};
      for (int c = 0; c < 40; c++) begin
         if (sent == 5 && got == 5) break;
         out_ready = !(c >= 2 && c <= 4);
         in_valid = (sent < 5);
         in_inst = bp_inst[sent % 5];
         in_tag = 32'h100 + sent;
         if (c == 3) begin
            n_cmp++;
            if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
               n_fail++; $display("FAIL bp_full_ready: got %b/%b want 0", rdy32, rdy64);
            end
         end
         if (v32 && out_ready) begin
            e = ref_imm(bp_inst[got]);
            n_cmp++;
            if ({tag32, imm32, v64, tag64, imm64} !== {32'h100 + got, e[31:0], 1'b1, 32'h100 + got, e}) begin
               n_fail++; $display("FAIL bp_order #%0d: got tag=%h/%h imm=%h/%h want tag=%h imm=%h",
                                  got, tag32, tag64, imm32, imm64, 32'h100 + got, e);
            end
            got++;
         end
         if (in_valid && q.size() < 2) sent++;
         tick();
      end
      in_valid = 1'b0;
      n_cmp++;
      if (got != 5 || v32 !== 1'b0) begin
         n_fail++; $display("FAIL bp_count: got %0d entries (out_valid=%b) want 5 and empty", got, v32);
      end
      drain();
   endtask

   task automatic test_flush();
      int c0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_inst = 32'h0000007F;
      in_tag = 32'hF1;
      tick();
      tick();
      c0 = mcnt;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      n_cmp++;
      if ({v32, v64, rdy32, rdy64} !== 4'b0011 || cnt32 !== 16'(c0)) begin
         n_fail++; $display("FAIL flush_full: got v=%b%b rdy=%b%b cnt=%0d want v=00 rdy=11 cnt=%0d",
                            v32, v64, rdy32, rdy64, cnt32, c0);
      end
      in_valid = 1'b1;
      tick();
      c0 = mcnt;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      n_cmp++;
      if ({v32, v64, rdy32, rdy64} !== 4'b0011 || cnt32 !== 16'(c0)) begin
         n_fail++; $display("FAIL flush_accept: got v=%b%b rdy=%b%b cnt=%0d want v=00 rdy=11 cnt=%0d",
                            v32, v64, rdy32, rdy64, cnt32, c0);
      end
      drain();
   endtask

   task automatic test_random();
      logic [63:0] ei;
      logic [2:0]  ef;
      bit          er;
      ent_t        e;
      for (int c = 0; c < 400; c++) begin
         er = (q.size() < 2);
         n_cmp++;
         if ({rdy32, rdy64, v32, v64} !== {er, er, q.size() > 0, q.size() > 0}) begin
            n_fail++; $display("FAIL rnd_hs cyc %0d: got rdy=%b%b v=%b%b want rdy=%b v=%b",
                               c, rdy32, rdy64, v32, v64, er, q.size() > 0);
         end
         if (q.size() > 0) begin
            e = q[0];
            ei = ref_imm(e.inst);
            ef = ref_fmt(e.inst);
            n_cmp++;
            if ({imm32, fmt32, ill32, tag32} !== {ei[31:0], ef, ef == 3'd7, e.tag} ||
                {imm64, fmt64, ill64, tag64} !== {ei, ef, ef == 3'd7, e.tag}) begin
               n_fail++; $display("FAIL rnd_data cyc %0d inst %h: got imm=%h/%h fmt=%0d/%0d tag=%h want imm=%h fmt=%0d tag=%h",
                                  c, e.inst, imm32, imm64, fmt32, fmt64, tag32, ei, ef, e.tag);
            end
         end
         n_cmp++;
         if (cnt32 !== 16'(mcnt) || cnt64 !== ((mcnt > 3) ? 2'd3 : 2'(mcnt))) begin
            n_fail++; $display("FAIL rnd_cnt cyc %0d: got %0d/%0d want %0d (sat 3)", c, cnt32, cnt64, mcnt);
         end
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 19) == 0);
         in_inst = rand_inst();
         in_tag = $urandom();
         tick();
      end
      drain();
   endtask

   task automatic test_saturation();
      int c0;
      c0 = mcnt;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_inst = 32'h0000007F;
      repeat (5) tick();
      in_valid = 1'b0;
      n_cmp++;
      if (cnt64 !== 2'd3 || cnt32 !== 16'(c0 + 5)) begin
         n_fail++; $display("FAIL saturation: got %0d/%0d want 3/%0d", cnt64, cnt32, c0 + 5);
      end
      drain();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_inst = 32'h0000007F;
      in_tag = 32'hBEEF;
      tick();
      tick();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({v32, v64, rdy32, rdy64} !== 4'b0011 || cnt32 !== 16'd0 || cnt64 !== 2'd0 || tag32 !== 32'd0) begin
         n_fail++; $display("FAIL async_reset: got v=%b%b rdy=%b%b cnt=%0d/%0d tag=%h want v=00 rdy=11 cnt=0 tag=0",
                            v32, v64, rdy32, rdy64, cnt32, cnt64, tag32);
      end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      mcnt = 0;
   endtask

   initial begin
      test_reset();
      test_decode();
      test_backpressure();
      test_flush();
      test_random();
      test_saturation();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
